// File: rtl/pipe_credit_fifo.sv
// Credit-managed elastic FIFO that captures the results of a fixed-latency pipe.
// Credits cover in-flight pipe entries plus FIFO occupancy; the output is first-word fall-through.
module pipe_credit_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             pv,
    input  logic [WIDTH-1:0] pd,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    credits,
    output logic [1:0]       err
);
    localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [PW-1:0] LastPtr   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_credits;
    logic [1:0]       r_err;

    logic          w_full;
    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic [PW-1:0] w_rd_ptr_d;
    logic [PW-1:0] w_wr_ptr_d;
    logic [CW-1:0] w_count_d;
    logic [CW-1:0] w_credits_d;
    logic [1:0]    w_err_d;

    assign w_full   = (r_count == FullCount);
    assign o_valid  = (r_count != '0);
    assign issue_ok = (r_credits != '0);
    assign w_accept = issue & issue_ok;
    assign w_pop    = o_valid & o_ready;
    // When full, a same-cycle pop frees the slot the incoming word lands in.
    assign w_push   = pv & (~w_full | w_pop);
    assign o_data   = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign credits  = r_credits;
    assign err      = r_err;

    always_comb begin
        w_rd_ptr_d  = r_rd_ptr;
        w_wr_ptr_d  = r_wr_ptr;
        w_count_d   = r_count;
        w_credits_d = r_credits;
        w_err_d     = r_err | {pv & w_full & ~w_pop, issue & ~issue_ok};

        if (w_pop) begin
            w_rd_ptr_d = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PW'(1);
        end
        if (w_push) begin
            w_wr_ptr_d = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PW'(1);
        end

        if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - CW'(1);
        end

        // Unsolicited words can return extra credits; never count above DEPTH.
        if (w_accept && !w_pop) begin
            w_credits_d = r_credits - CW'(1);
        end else if (w_pop && !w_accept && (r_credits != FullCount)) begin
            w_credits_d = r_credits + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_credits <= FullCount;
            r_err     <= '0;
        end else begin
            r_rd_ptr  <= w_rd_ptr_d;
            r_wr_ptr  <= w_wr_ptr_d;
            r_count   <= w_count_d;
            r_credits <= w_credits_d;
            r_err     <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pd;
        end
    end

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Bench for pipe_credit_fifo: three instances (DEPTH 4/6/5) fed by modelled fixed-delay pipes,
// checked every cycle against a queue-level reference plus directed scenario checks.
module tb_pipe_credit_fifo;
    localparam int DEP [3] = '{4, 6, 5};
    localparam int DLY [3] = '{2, 4, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_s    [3];
    logic        issue_ok_s [3];
    logic        pv_s       [3];
    logic [15:0] pd_s       [3];
    logic        o_valid_s  [3];
    logic        o_ready_s  [3];
    logic [15:0] o_data_s   [3];
    logic [2:0]  count_s    [3];
    logic [2:0]  credits_s  [3];
    logic [1:0]  err_s      [3];

    always #5 clk = ~clk;

    pipe_credit_fifo #(.WIDTH(16), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .issue(issue_s[0]), .issue_ok(issue_ok_s[0]),
        .pv(pv_s[0]), .pd(pd_s[0]), .o_valid(o_valid_s[0]), .o_ready(o_ready_s[0]),
        .o_data(o_data_s[0]), .count(count_s[0]), .credits(credits_s[0]), .err(err_s[0])
    );
    pipe_credit_fifo #(.WIDTH(16), .DEPTH(6)) u_d6 (
        .clk(clk), .reset(reset), .issue(issue_s[1]), .issue_ok(issue_ok_s[1]),
        .pv(pv_s[1]), .pd(pd_s[1]), .o_valid(o_valid_s[1]), .o_ready(o_ready_s[1]),
        .o_data(o_data_s[1]), .count(count_s[1]), .credits(credits_s[1]), .err(err_s[1])
    );
    pipe_credit_fifo #(.WIDTH(16), .DEPTH(5)) u_d5 (
        .clk(clk), .reset(reset), .issue(issue_s[2]), .issue_ok(issue_ok_s[2]),
        .pv(pv_s[2]), .pd(pd_s[2]), .o_valid(o_valid_s[2]), .o_ready(o_ready_s[2]),
        .o_data(o_data_s[2]), .count(count_s[2]), .credits(credits_s[2]), .err(err_s[2])
    );

    // Stimulus controls
    logic        iss   [3];
    logic        rdy   [3];
    logic [15:0] din   [3];
    logic        inj_v [3];
    logic [15:0] inj_d [3];

    // Pipe model and queue-level reference
    logic        pp_v [3][8];
    logic [15:0] pp_d [3][8];
    int          m_cred [3];
    int          m_push [3];
    int          m_pop  [3];
    logic [1:0]  m_err  [3];
    logic [15:0] hist   [3][1024];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    bit tp_on  = 0;
    int cyc    = 0;
    int tp_exp = 0;
    int first_iss = -1;
    int first_val = -1;
    int np_pops = 0;
    logic [15:0] drain_exp [4] = '{16'hA1, 16'hA2, 16'hA3, 16'hE0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int  mcnt;
        bit  pop, full, push, acc;
        for (int k = 0; k < 3; k++) begin
            pv_s[k]      = pp_v[k][DLY[k]-1] | inj_v[k];
            pd_s[k]      = inj_v[k] ? inj_d[k] : pp_d[k][DLY[k]-1];
            issue_s[k]   = iss[k];
            o_ready_s[k] = rdy[k];
        end
        #1;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                mcnt = m_push[k] - m_pop[k];
                chk($sformatf("count[%0d]", k), 32'(count_s[k]), mcnt);
                chk($sformatf("credits[%0d]", k), 32'(credits_s[k]), m_cred[k]);
                chk($sformatf("issue_ok[%0d]", k), 32'(issue_ok_s[k]), 32'(m_cred[k] != 0));
                chk($sformatf("o_valid[%0d]", k), 32'(o_valid_s[k]), 32'(mcnt != 0));
                chk($sformatf("err[%0d]", k), 32'(err_s[k]), 32'(m_err[k]));
                if (mcnt != 0) begin
                    chk($sformatf("o_data[%0d]", k), 32'(o_data_s[k]), 32'(hist[k][m_pop[k]]));
                end
            end
            chk("d5_count_le_5", 32'(count_s[2] <= 3'd5), 32'd1);
        end
        if (o_valid_s[2] && rdy[2]) np_pops++;
        if (tp_on) begin
            if (iss[1] && first_iss < 0) first_iss = cyc;
            if (o_valid_s[1] && first_val < 0) first_val = cyc;
            if (iss[1]) chk("tp_issue_ok", 32'(issue_ok_s[1]), 32'd1);
            if (o_valid_s[1] && rdy[1]) begin
                chk("tp_order", 32'(o_data_s[1]), tp_exp);
                tp_exp++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_cred[k] = DEP[k];
                m_push[k] = 0;
                m_pop[k]  = 0;
                m_err[k]  = 2'b00;
                for (int i = 0; i < 8; i++) pp_v[k][i] = 1'b0;
            end else begin
                mcnt = m_push[k] - m_pop[k];
                pop  = (mcnt != 0) && rdy[k];
                full = (mcnt == DEP[k]);
                push = pv_s[k] && (!full || pop);
                acc  = iss[k] && (m_cred[k] != 0);
                if (iss[k] && m_cred[k] == 0) m_err[k][0] = 1'b1;
                if (pv_s[k] && full && !pop) m_err[k][1] = 1'b1;
                m_cred[k] = m_cred[k] - int'(acc) + int'(pop);
                if (m_cred[k] > DEP[k]) m_cred[k] = DEP[k];
                if (pop) m_pop[k]++;
                if (push) begin
                    hist[k][m_push[k]] = pd_s[k];
                    m_push[k]++;
                end
                for (int i = 7; i > 0; i--) begin
                    pp_v[k][i] = pp_v[k][i-1];
                    pp_d[k][i] = pp_d[k][i-1];
                end
                pp_v[k][0] = iss[k];
                pp_d[k][0] = din[k];
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iss[k] = 0; rdy[k] = 0; din[k] = '0; inj_v[k] = 0; inj_d[k] = '0;
            m_cred[k] = DEP[k]; m_push[k] = 0; m_pop[k] = 0; m_err[k] = '0;
            for (int i = 0; i < 8; i++) begin
                pp_v[k][i] = 1'b0;
                pp_d[k][i] = '0;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        cycle();
        chk_en = 1;
        cycle();
        reset = 1'b0;

        // Reset then idle (DEPTH=4)
        chk("rst_credits", 32'(credits_s[0]), 32'd4);
        chk("rst_issue_ok", 32'(issue_ok_s[0]), 32'd1);
        chk("rst_o_valid", 32'(o_valid_s[0]), 32'd0);
        chk("rst_count", 32'(count_s[0]), 32'd0);
        chk("rst_err", 32'(err_s[0]), 32'd0);

        // Full throughput (DEPTH=6, DELAY=4)
        tp_on = 1;
        rdy[1] = 1;
        for (int i = 0; i < 20; i++) begin
            iss[1] = 1;
            din[1] = 16'(i);
            cycle();
        end
        iss[1] = 0;
        repeat (10) cycle();
        tp_on = 0;
        rdy[1] = 0;
        chk("tp_first_valid_lat", first_val - first_iss, 32'd5);
        chk("tp_words_out", tp_exp, 32'd20);
        chk("tp_err", 32'(err_s[1]), 32'd0);

        // Back-pressure, then full with simultaneous pop and push (DEPTH=4, DELAY=2)
        for (int i = 0; i < 4; i++) begin
            iss[0] = 1;
            din[0] = 16'hA0 + 16'(i);
            cycle();
        end
        iss[0] = 0;
        chk("bp_issue_ok_low", 32'(issue_ok_s[0]), 32'd0);
        repeat (2) cycle();
        chk("bp_count_full", 32'(count_s[0]), 32'd4);
        chk("bp_head_A", 32'(o_data_s[0]), 32'h00A0);
        rdy[0] = 1; inj_v[0] = 1; inj_d[0] = 16'hE0;
        cycle();
        rdy[0] = 0; inj_v[0] = 0;
        chk("bp_credit_return", 32'(credits_s[0]), 32'd1);
        chk("fpp_count_stays", 32'(count_s[0]), 32'd4);
        chk("bp_head_popped", 32'(o_data_s[0]), 32'h00A1);

        // Error flags
        inj_v[0] = 1; inj_d[0] = 16'hF0;
        cycle();
        inj_v[0] = 0;
        chk("ovf_err1", 32'(err_s[0]), 32'd2);
        chk("ovf_count", 32'(count_s[0]), 32'd4);
        chk("ovf_head", 32'(o_data_s[0]), 32'h00A1);
        iss[0] = 1; din[0] = 16'hBB;
        cycle();
        chk("legal_last_credit", 32'(credits_s[0]), 32'd0);
        cycle();
        iss[0] = 0;
        chk("illegal_err0", 32'(err_s[0]), 32'd3);
        chk("illegal_credits_sat", 32'(credits_s[0]), 32'd0);
        repeat (3) cycle();
        rdy[0] = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(o_valid_s[0]), 32'd1);
            chk("drain_order", 32'(o_data_s[0]), 32'(drain_exp[i]));
            cycle();
        end
        rdy[0] = 0;
        chk("drain_count", 32'(count_s[0]), 32'd0);
        chk("drain_credits", 32'(credits_s[0]), 32'd4);
        chk("err_sticky", 32'(err_s[0]), 32'd3);

        // Random legal traffic on all instances (DEPTH=5 exercises non-power-of-two wrap)
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst2_err", 32'(err_s[0]), 32'd0);
        np_pops = 0;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 3; k++) begin
                rdy[k] = ($urandom_range(0, 2) != 0);
                iss[k] = (m_cred[k] != 0) && ($urandom_range(0, 3) != 0);
                din[k] = 16'($urandom);
            end
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            iss[k] = 0;
            rdy[k] = 1;
        end
        repeat (12) cycle();
        chk("d5_popped_ge_12", 32'(np_pops >= 12), 32'd1);
        chk("d5_drained", 32'(count_s[2]), 32'd0);
        chk("d5_credits_back", 32'(credits_s[2]), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
